sc_decode_sched: RTL

Successive-cancellation (SC) schedule controller for the polar decoder datapath. For one N = 2^LOG_N codeword it issues the ordered sequence of f, g and leaf-decision operations to the LLR datapath (the f/g engine built around LLRg) over a valid/ready handshake. It applies the frozen-bit mask to each returned leaf decision, broadcasts each decided bit for partial-sum update, and collects the decoded vector u_hat.

---
 rtl/sc_decode_sched_if.sv | 21 ++
 rtl/sc_decode_sched.sv | 97 +++++++++
 2 files changed

// File: rtl/sc_decode_sched_if.sv
// sc_decode_sched_if: op request channel to the f/g/leaf datapath plus its leaf result strobe.
interface sc_decode_sched_if #(
    parameter int LOG_N = 3,
    parameter int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1
);
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_type;
    logic [SW-1:0]    op_stage;
    logic [LOG_N-1:0] op_node;
    logic             res_valid;
    logic             res_sign;
    modport master (
        output op_valid, op_type, op_stage, op_node,
        input  op_ready, res_valid, res_sign
    );
    modport slave (
        input  op_valid, op_type, op_stage, op_node,
        output op_ready, res_valid, res_sign
    );
endinterface

// File: rtl/sc_decode_sched.sv
// sc_decode_sched: successive-cancellation schedule controller for one polar codeword.
// Issues f/g/leaf ops over valid/ready and collects frozen-masked leaf decisions into u_hat.
module sc_decode_sched #(
    parameter int LOG_N = 3,
    parameter logic [(1<<LOG_N)-1:0] FROZEN_MASK = 8'b0001_0111
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   u_valid,
    output logic                   u_bit,
    output logic [LOG_N-1:0]       u_index,
    output logic [(1<<LOG_N)-1:0]  u_hat,
    sc_decode_sched_if.master      io
);
    localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
    typedef enum logic [2:0] {IDLE, ISSUE, LEAF_REQ, LEAF_WAIT, DONE} state_t;
    state_t           state, state_n;
    logic [LOG_N-1:0] i, i_n, i_inc;
    logic [SW-1:0]    s, s_n;
    logic             b, take;

    function automatic logic [SW-1:0] ctz(input logic [LOG_N-1:0] x);
        ctz = '0;
        for (int k = LOG_N - 1; k >= 0; k--) if (x[k]) ctz = SW'(k);
    endfunction

    assign i_inc       = i + 1'b1;
    assign take        = (state == LEAF_WAIT) && io.res_valid;
    assign b           = FROZEN_MASK[i] ? 1'b0 : io.res_sign;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign io.op_valid = (state == ISSUE) || (state == LEAF_REQ);

    always_comb begin
        state_n = state;
        i_n     = i;
        s_n     = s;
        case (state)
            IDLE: if (start) begin
                state_n = ISSUE;
                i_n     = '0;
                s_n     = SW'(LOG_N - 1);
            end
            ISSUE: if (io.op_ready) begin
                if (s == '0) state_n = LEAF_REQ;
                else s_n = s - 1'b1;
            end
            LEAF_REQ: if (io.op_ready) state_n = LEAF_WAIT;
            LEAF_WAIT: if (io.res_valid) begin
                if (&i) state_n = DONE;
                else begin
                    state_n = ISSUE;
                    i_n     = i_inc;
                    s_n     = ctz(i_inc);
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            s     <= '0;
        end else begin
            state <= state_n;
            i     <= i_n;
            s     <= s_n;
        end

    // op fields are computed from next-state values so they are valid from the first ISSUE cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            io.op_type  <= '0;
            io.op_stage <= '0;
            io.op_node  <= '0;
            u_valid     <= 1'b0;
            u_bit       <= 1'b0;
            u_index     <= '0;
            u_hat       <= '0;
        end else begin
            io.op_type  <= (state_n == LEAF_REQ) ? 2'b10 : {1'b0, i_n[s_n]};
            io.op_stage <= (state_n == LEAF_REQ) ? '0 : s_n;
            io.op_node  <= (state_n == LEAF_REQ) ? i_n : i_n >> s_n;
            u_valid     <= take;
            if (take) begin
                u_bit      <= b;
                u_index    <= i;
                u_hat[i]   <= b;
            end else if (state == IDLE && start) u_hat <= '0;
        end
endmodule
